// File: rtl/pin_delay_pkg.sv
// Shared types and helpers for the pin-to-pin delay meter.
// Provides the FSM state type, the pin index codes and two small helpers
// that classify the set of input bits that changed in one sample.
`timescale 1ns/1ps
package pin_delay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [1:0] PIN_A = 2'd3;
  localparam logic [1:0] PIN_B = 2'd2;
  localparam logic [1:0] PIN_C = 2'd1;
  localparam logic [1:0] PIN_D = 2'd0;

  // Index of the most significant set bit; a takes priority over b, c, d.
  function automatic logic [1:0] highest_bit(input logic [3:0] v);
    if (v[3])      return PIN_A;
    else if (v[2]) return PIN_B;
    else if (v[1]) return PIN_C;
    else           return PIN_D;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit
  // leaves something behind only if a second bit was present.
  function automatic logic multi_bit(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/pin_delay_meter_sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs.
// Ports:
//   clk    sampling clock
//   rst_n  asynchronous active-low reset, clears every stage
//   i_d    asynchronous input bundle (WIDTH bits)
//   o_q    synchronized output, DEPTH clocks behind i_d
`timescale 1ns/1ps
module sync_ff #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Stage 0 captures the raw input; the last stage is the safe output.
  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/pin_delay_meter.sv
// Measures the cycle delay from a toggle on one of four stimulus pins to
// the response of the downstream cell output, and reports pin, delay,
// timeout and multi-toggle flags over a valid/ready handshake.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   arm            level enable for measurement
//   in_vec[3:0]    asynchronous stimulus (bit3=a .. bit0=d)
//   q_in           asynchronous cell output
//   meas_ready     consumer accepts the current result
//   meas_valid     result available, held until accepted
//   meas_pin       index of the highest toggled pin
//   meas_delay     cycles from input change to output change
//   meas_timeout   output did not respond within TIMEOUT cycles
//   meas_multi     more than one input bit changed in the trigger sample
//   busy           a measurement is counting
`timescale 1ns/1ps
module pin_delay_meter
  import pin_delay_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic [3:0]       in_vec,
  input  logic             q_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [1:0]       meas_pin,
  output logic [CNT_W-1:0] meas_delay,
  output logic             meas_timeout,
  output logic             meas_multi,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

  logic [4:0]       w_sync;
  logic [3:0]       w_in_s;
  logic             w_q_s;
  logic [3:0]       w_in_diff;
  logic             w_in_chg;
  logic             w_q_chg;
  logic [CNT_W-1:0] w_cnt_inc;

  state_t           r_state;
  logic [3:0]       r_in_b;
  logic             r_q_b;
  logic [CNT_W-1:0] r_cnt;

  // Both paths share one synchronizer so their latencies cancel exactly.
  sync_ff #(
    .DEPTH (SYNC_STAGES),
    .WIDTH (5)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({in_vec, q_in}),
    .o_q   (w_sync)
  );

  assign w_in_s    = w_sync[4:1];
  assign w_q_s     = w_sync[0];
  assign w_in_diff = w_in_s ^ r_in_b;
  assign w_in_chg  = |w_in_diff;
  assign w_q_chg   = w_q_s ^ r_q_b;
  // Counter never exceeds TIMEOUT-1, so the increment cannot wrap.
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_in_b       <= '0;
      r_q_b        <= 1'b0;
      r_cnt        <= '0;
      meas_valid   <= 1'b0;
      meas_pin     <= '0;
      meas_delay   <= '0;
      meas_timeout <= 1'b0;
      meas_multi   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state <= ARMED;
            r_in_b  <= w_in_s;
            r_q_b   <= w_q_s;
          end
        end
        ARMED: begin
          if (!arm) begin
            r_state <= IDLE;
          end else if (w_in_chg) begin
            meas_pin     <= highest_bit(w_in_diff);
            meas_multi   <= multi_bit(w_in_diff);
            meas_timeout <= 1'b0;
            r_in_b       <= w_in_s;
            r_cnt        <= '0;
            // Output already moved in the same sample: zero-cycle path.
            if (w_q_chg) begin
              r_q_b      <= w_q_s;
              meas_delay <= '0;
              meas_valid <= 1'b1;
              r_state    <= REPORT;
            end else begin
              busy    <= 1'b1;
              r_state <= COUNT;
            end
          end else if (w_q_chg) begin
            // Output moved on its own; track it without reporting.
            r_q_b <= w_q_s;
          end
        end
        COUNT: begin
          if (!arm) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (w_q_chg) begin
            r_q_b      <= w_q_s;
            meas_delay <= w_cnt_inc;
            meas_valid <= 1'b1;
            busy       <= 1'b0;
            r_state    <= REPORT;
          end else if (w_cnt_inc == LP_TIMEOUT) begin
            meas_delay   <= LP_TIMEOUT;
            meas_timeout <= 1'b1;
            meas_valid   <= 1'b1;
            busy         <= 1'b0;
            r_state      <= REPORT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        REPORT: begin
          // Inputs moving while the result waits are absorbed by re-baselining.
          if (meas_ready) begin
            meas_valid <= 1'b0;
            r_in_b     <= w_in_s;
            r_q_b      <= w_q_s;
            r_state    <= arm ? ARMED : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_delay_meter.sv
`timescale 1ns/1ps
module tb_pin_delay_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic [3:0] in_vec;
  logic       q_in;
  logic       meas_ready;
  logic       meas_valid;
  logic [1:0] meas_pin;
  logic [7:0] meas_delay;
  logic       meas_timeout;
  logic       meas_multi;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  pin_delay_meter #(
    .CNT_W       (8),
    .TIMEOUT     (200),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .in_vec       (in_vec),
    .q_in         (q_in),
    .meas_ready   (meas_ready),
    .meas_valid   (meas_valid),
    .meas_pin     (meas_pin),
    .meas_delay   (meas_delay),
    .meas_timeout (meas_timeout),
    .meas_multi   (meas_multi),
    .busy         (busy)
  );

  always #1 clk = ~clk;

  // Bounded wait for a report, sampled on falling edges.
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // All inputs high, cell output high, then arm with a settled baseline.
  task automatic settle_ones();
    @(negedge clk);
    arm    = 1'b0;
    in_vec = 4'hF;
    q_in   = 1'b1;
    repeat (5) @(negedge clk);
    arm = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    arm        = 1'b0;
    in_vec     = 4'hF;
    q_in       = 1'b1;
    meas_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({meas_valid, meas_pin, meas_delay, meas_timeout, meas_multi, busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {meas_valid, meas_pin, meas_delay, meas_timeout, meas_multi, busy});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_valid got=%b want=0", meas_valid);
    end
  endtask

  // AND4 path delays a=10, b=12, c=18, d=22; with mid-cycle launch the
  // measured delay is exactly path/2 cycles.
  task automatic test_single_pins();
    int idx_t   [4] = '{0, 1, 2, 3};
    int path_t  [4] = '{22, 18, 12, 10};
    int exp_t   [4] = '{11, 9, 6, 5};
    bit ok;
    for (int k = 0; k < 4; k++) begin
      settle_ones();
      in_vec[idx_t[k]] = 1'b0;
      #(path_t[k]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_pin%0d got=%b want=1", idx_t[k], busy);
      end
      q_in = &in_vec;
      wait_valid(40, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL valid_pin%0d got=0 want=1", idx_t[k]);
      end
      checks++;
      if (meas_pin !== 2'(idx_t[k])) begin
        failures++;
        $display("FAIL pin_pin%0d got=%0d want=%0d", idx_t[k], meas_pin, idx_t[k]);
      end
      checks++;
      if (meas_delay !== 8'(exp_t[k])) begin
        failures++;
        $display("FAIL delay_pin%0d got=%0d want=%0d", idx_t[k], meas_delay, exp_t[k]);
      end
      checks++;
      if ({meas_timeout, meas_multi} !== 2'b00) begin
        failures++;
        $display("FAIL flags_pin%0d got=%b want=00", idx_t[k], {meas_timeout, meas_multi});
      end
      @(negedge clk);
      checks++;
      if (meas_valid !== 1'b0) begin
        failures++;
        $display("FAIL accept_pin%0d got=%b want=0", idx_t[k], meas_valid);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    @(negedge clk);
    arm    = 1'b0;
    in_vec = 4'hF;
    q_in   = 1'b0;
    repeat (5) @(negedge clk);
    arm = 1'b1;
    repeat (4) @(negedge clk);
    in_vec[2] = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got=valid%b busy%b want=valid0 busy1", meas_valid, busy);
    end
    wait_valid(150, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_valid got=0 want=1");
    end
    checks++;
    if ({meas_timeout, meas_delay, meas_pin, meas_multi} !== {1'b1, 8'd200, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL timeout_fields got=to%b d%0d p%0d m%b want=to1 d200 p2 m0",
               meas_timeout, meas_delay, meas_pin, meas_multi);
    end
  endtask

  task automatic test_multi();
    bit ok;
    settle_ones();
    in_vec = 4'b0110;
    #10;
    q_in = &in_vec;
    wait_valid(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL multi_valid got=0 want=1");
    end
    checks++;
    if ({meas_pin, meas_multi, meas_timeout, meas_delay} !== {2'd3, 1'b1, 1'b0, 8'd5}) begin
      failures++;
      $display("FAIL multi_fields got=p%0d m%b to%b d%0d want=p3 m1 to0 d5",
               meas_pin, meas_multi, meas_timeout, meas_delay);
    end
  endtask

  task automatic test_ready_hold();
    bit ok;
    int extra;
    settle_ones();
    meas_ready = 1'b0;
    in_vec[0]  = 1'b0;
    #22;
    q_in = &in_vec;
    wait_valid(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_valid got=0 want=1");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 6) in_vec[1] = ~in_vec[1];
      checks++;
      if ({meas_valid, meas_pin, meas_delay, meas_timeout, meas_multi} !==
          {1'b1, 2'd0, 8'd11, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle%0d got=v%b p%0d d%0d to%b m%b want=v1 p0 d11 to0 m0",
                 i, meas_valid, meas_pin, meas_delay, meas_timeout, meas_multi);
      end
    end
    meas_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_accept got=%b want=0", meas_valid);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (meas_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL hold_single_report got=%0d extra want=0", extra);
    end
  endtask

  task automatic test_reset_mid_count();
    bit ok;
    settle_ones();
    in_vec[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got=%b want=1", busy);
    end
    rst_n = 1'b0;
    arm   = 1'b0;
    #0.25;
    checks++;
    if ({meas_valid, meas_pin, meas_delay, meas_timeout, meas_multi, busy} !== 14'd0) begin
      failures++;
      $display("FAIL midrst_async got=%h want=0",
               {meas_valid, meas_pin, meas_delay, meas_timeout, meas_multi, busy});
    end
    @(negedge clk);
    q_in = &in_vec;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_report got=%b want=0", meas_valid);
    end
    settle_ones();
    in_vec[0] = 1'b0;
    #22;
    q_in = &in_vec;
    wait_valid(40, ok);
    checks++;
    if (!ok || {meas_pin, meas_delay, meas_timeout} !== {2'd0, 8'd11, 1'b0}) begin
      failures++;
      $display("FAIL midrst_remeasure got=ok%b p%0d d%0d to%b want=ok1 p0 d11 to0",
               ok, meas_pin, meas_delay, meas_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_single_pins();
    test_timeout();
    test_multi();
    test_ready_hold();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
